// File: rtl/lane_serializer.sv
// Parallel-to-serial lane converter with start/last framing,
// a one-word holding buffer and a programmable inter-frame gap.
module lane_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] parallel_in,
  input  logic                  lsb_first,
  input  logic                  valid,
  output logic                  ready,
  output logic [LANES-1:0]      serial_out,
  output logic                  enable,
  output logic                  start,
  output logic                  last,
  output logic                  busy
);

  localparam int BEATS = DATA_WIDTH / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [7:0] GAP_LAST =
    8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  generate
    if (DATA_WIDTH < 2) begin : g_bad_width
      $error("DATA_WIDTH must be at least 2");
    end
    if (DATA_WIDTH % LANES != 0) begin : g_bad_lanes
      $error("DATA_WIDTH must be a multiple of LANES");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
      $error("GAP_CYCLES must be in 0..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_sh;
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  r_lsb;
  logic                  r_buf_lsb;
  logic                  r_buf_full;
  logic [BW-1:0]         r_beat;
  logic [7:0]            r_gap;

  logic                  w_accept;
  logic                  w_final;
  logic                  w_free;
  logic                  w_launch;
  logic                  w_buf_wr;
  logic [DATA_WIDTH-1:0] w_ld_word;
  logic                  w_ld_lsb;

  assign ready    = !r_buf_full && !rst;
  assign w_accept = valid && ready;
  assign w_final  = (r_state == S_SHIFT) && (r_beat == LAST_BEAT);

  // Buffered word always wins; otherwise bypass the incoming word.
  assign w_ld_word = r_buf_full ? r_buf : parallel_in;
  assign w_ld_lsb  = r_buf_full ? r_buf_lsb : lsb_first;

  always_comb begin
    w_free      = 1'b0;
    w_state_nxt = r_state;
    enable      = 1'b0;
    start       = 1'b0;
    last        = 1'b0;
    serial_out  = '0;
    unique case (r_state)
      S_IDLE:  w_free = 1'b1;
      S_SHIFT: w_free = w_final && (GAP_CYCLES == 0);
      S_GAP:   w_free = (r_gap == GAP_LAST);
      default: w_free = 1'b0;
    endcase
    w_launch = w_free && (r_buf_full || w_accept);
    w_buf_wr = w_accept && !(w_launch && !r_buf_full);
    unique case (r_state)
      S_IDLE: begin
        if (w_launch) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_final) begin
          if (w_launch)            w_state_nxt = S_SHIFT;
          else if (GAP_CYCLES > 0) w_state_nxt = S_GAP;
          else                     w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (w_free) w_state_nxt = w_launch ? S_SHIFT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (r_state == S_SHIFT) begin
      enable     = 1'b1;
      start      = (r_beat == '0);
      last       = w_final;
      serial_out = r_lsb ? r_sh[LANES-1:0]
                         : r_sh[DATA_WIDTH-1 -: LANES];
    end
  end

  assign busy = (r_state != S_IDLE) || r_buf_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sh       <= '0;
      r_lsb      <= 1'b0;
      r_beat     <= '0;
      r_gap      <= '0;
      r_buf      <= '0;
      r_buf_lsb  <= 1'b0;
      r_buf_full <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_sh   <= w_ld_word;
        r_lsb  <= w_ld_lsb;
        r_beat <= '0;
      end else if (r_state == S_SHIFT) begin
        r_sh   <= r_lsb ? (r_sh >> LANES) : (r_sh << LANES);
        r_beat <= r_beat + BW'(1);
      end
      if (r_state == S_GAP) r_gap <= r_gap + 8'd1;
      else                  r_gap <= '0;
      if (w_buf_wr) begin
        r_buf      <= parallel_in;
        r_buf_lsb  <= lsb_first;
        r_buf_full <= 1'b1;
      end else if (w_launch && r_buf_full) begin
        r_buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: three configurations checked every
// cycle against a frame-schedule model plus directed literals.
module tb_lane_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pdata = 8'h00;
  logic       plsb = 1'b0;
  logic [2:0] vld = 3'b000;

  logic [2:0] d_rdy, d_en, d_st, d_la, d_bz;
  logic [0:0] so_a;
  logic [1:0] so_b;
  logic [7:0] so_c;
  logic [7:0] d_so [3];

  always #5 clk = ~clk;

  assign d_so[0] = {7'd0, so_a};
  assign d_so[1] = {6'd0, so_b};
  assign d_so[2] = so_c;

  lane_serializer #(.DATA_WIDTH(8), .LANES(1), .GAP_CYCLES(0)) u_a (
    .clk(clk), .rst(rst), .parallel_in(pdata), .lsb_first(plsb),
    .valid(vld[0]), .ready(d_rdy[0]), .serial_out(so_a),
    .enable(d_en[0]), .start(d_st[0]), .last(d_la[0]), .busy(d_bz[0])
  );

  lane_serializer #(.DATA_WIDTH(8), .LANES(2), .GAP_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .parallel_in(pdata), .lsb_first(plsb),
    .valid(vld[1]), .ready(d_rdy[1]), .serial_out(so_b),
    .enable(d_en[1]), .start(d_st[1]), .last(d_la[1]), .busy(d_bz[1])
  );

  lane_serializer #(.DATA_WIDTH(8), .LANES(8), .GAP_CYCLES(0)) u_c (
    .clk(clk), .rst(rst), .parallel_in(pdata), .lsb_first(plsb),
    .valid(vld[2]), .ready(d_rdy[2]), .serial_out(so_c),
    .enable(d_en[2]), .start(d_st[2]), .last(d_la[2]), .busy(d_bz[2])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int LN [3] = '{1, 2, 8};
  int GP [3] = '{0, 2, 0};

  // A frame occupies cycles s..e; its word waits in the buffer a..s-1.
  typedef struct {
    int         inst;
    int         a;
    int         s;
    int         e;
    logic [7:0] w;
    bit         l;
  } frame_t;

  frame_t fq[$];
  int     last_e [3] = '{-1000, -1000, -1000};
  int     acc_edge [3] = '{-1, -1, -1};
  bit     rdy_exp [3] = '{1'b0, 1'b0, 1'b0};

  function automatic int beat_of(input int lanes, input logic [7:0] w,
                                 input bit l, input int k);
    int sh;
    sh = l ? k * lanes : 8 - (k + 1) * lanes;
    return (int'(w) >> sh) & ((1 << lanes) - 1);
  endfunction

  always @(posedge clk) begin
    frame_t f;
    cyc++;
    if (rst) begin
      fq.delete();
      for (int i = 0; i < 3; i++) last_e[i] = -1000;
      chk_en = 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (chk_en && vld[i] && rdy_exp[i]) begin
          f.inst = i;
          f.a    = cyc;
          f.s    = (cyc > last_e[i] + GP[i] + 1) ? cyc
                                                  : last_e[i] + GP[i] + 1;
          f.e    = f.s + 8 / LN[i] - 1;
          f.w    = pdata;
          f.l    = plsb;
          fq.push_back(f);
          last_e[i]   = f.e;
          acc_edge[i] = cyc;
        end
      end
    end
    for (int j = fq.size() - 1; j >= 0; j--)
      if (fq[j].e + GP[fq[j].inst] < cyc) fq.delete(j);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit e_en, e_st, e_la, e_bz, e_rdy;
      int e_so;
      e_en = 0; e_st = 0; e_la = 0; e_bz = 0; e_so = 0;
      e_rdy = !rst;
      foreach (fq[j]) begin
        if (fq[j].inst == i) begin
          if (cyc >= fq[j].s && cyc <= fq[j].e) begin
            e_en = 1;
            e_st = (cyc == fq[j].s);
            e_la = (cyc == fq[j].e);
            e_so = beat_of(LN[i], fq[j].w, fq[j].l, cyc - fq[j].s);
          end
          if (cyc >= fq[j].a && cyc < fq[j].s) begin
            e_rdy = 0;
            e_bz  = 1;
          end
          if (cyc >= fq[j].s && cyc <= fq[j].e + GP[i]) e_bz = 1;
        end
      end
      rdy_exp[i] = e_rdy;
      if (chk_en) begin
        checks++;
        if (d_en[i] !== e_en || d_st[i] !== e_st || d_la[i] !== e_la ||
            d_bz[i] !== e_bz || d_rdy[i] !== e_rdy ||
            d_so[i] !== 8'(e_so)) begin
          failures++;
          $display("FAIL model inst%0d cyc%0d got en%b st%b la%b bz%b rdy%b so%0h want en%b st%b la%b bz%b rdy%b so%0h",
                   i, cyc, d_en[i], d_st[i], d_la[i], d_bz[i], d_rdy[i],
                   d_so[i], e_en, e_st, e_la, e_bz, e_rdy, e_so);
        end
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(input int i, input logic [7:0] w, input bit l);
    int n;
    pdata  = w;
    plsb   = l;
    vld[i] = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (acc_edge[i] != cyc && n < 100);
    if (acc_edge[i] != cyc) lit("accept_timeout", 0, 1);
    vld[i] = 1'b0;
  endtask

  task automatic collect(input int i, input int ncyc,
                         output int st, output int nb, output int ns,
                         output int nl, output int idle, output int rlow);
    int pend;
    bit seen;
    st = 0; nb = 0; ns = 0; nl = 0; idle = 0; rlow = 0;
    pend = 0; seen = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (!d_rdy[i]) rlow++;
      if (d_en[i]) begin
        st = (st << LN[i]) | int'(d_so[i]);
        nb++;
        if (d_st[i]) ns++;
        if (d_la[i]) nl++;
        idle += pend;
        pend = 0;
        seen = 1;
      end else if (seen) begin
        pend++;
      end
    end
  endtask

  int st, nb, ns, nl, idle, rlow;

  initial begin
    lit("model_a5_k0", beat_of(1, 8'hA5, 1'b0, 0), 1);
    lit("model_b4_msb_k0", beat_of(2, 8'hB4, 1'b0, 0), 2);
    lit("model_b4_lsb_k3", beat_of(2, 8'hB4, 1'b1, 3), 2);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    lit("reset_ready", int'(d_rdy), 7);
    lit("reset_enable", int'(d_en), 0);
    lit("reset_busy", int'(d_bz), 0);

    @(posedge clk); #1;
    fork
      send(0, 8'hA5, 1'b0);
      collect(0, 20, st, nb, ns, nl, idle, rlow);
    join
    lit("a5_stream", st, 32'hA5);
    lit("a5_beats", nb, 8);
    lit("a5_start_last", ns * 16 + nl, 16'h11);
    lit("a5_busy_after", int'(d_bz[0]), 0);

    @(posedge clk); #1;
    fork
      send(1, 8'hB4, 1'b0);
      collect(1, 15, st, nb, ns, nl, idle, rlow);
    join
    lit("b4_msb_stream", st, 32'hB4);
    lit("b4_msb_beats", nb, 4);
    fork
      send(1, 8'hB4, 1'b1);
      collect(1, 15, st, nb, ns, nl, idle, rlow);
    join
    lit("b4_lsb_stream", st, 32'h1E);
    lit("b4_lsb_last", nl, 1);

    @(posedge clk); #1;
    fork
      begin
        send(0, 8'h81, 1'b0);
        send(0, 8'h7E, 1'b1);
        send(0, 8'hFF, 1'b0);
      end
      collect(0, 40, st, nb, ns, nl, idle, rlow);
    join
    lit("b2b_stream", st, 32'h817EFF);
    lit("b2b_beats", nb, 24);
    lit("b2b_starts", ns, 3);
    lit("b2b_idle", idle, 0);
    lit("b2b_ready_low", rlow, 14);

    @(posedge clk); #1;
    fork
      begin
        send(1, 8'h0F, 1'b0);
        send(1, 8'hF0, 1'b0);
      end
      collect(1, 30, st, nb, ns, nl, idle, rlow);
    join
    lit("gap_stream", st, 32'h0FF0);
    lit("gap_idle", idle, 2);

    @(posedge clk); #1;
    send(0, 8'hC3, 1'b0);
    pdata  = 8'h3C;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    lit("rst_beat3_enable", int'(d_en[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    lit("rst_ready_low", int'(d_rdy[0]), 0);
    @(posedge clk); #1;
    lit("rst_outputs", int'({d_en[0], d_st[0], d_la[0], d_bz[0], so_a}), 0);
    rst = 1'b0;
    @(negedge clk);
    lit("rst_ready_after", int'(d_rdy[0]), 1);
    collect(0, 20, st, nb, ns, nl, idle, rlow);
    lit("rst_no_beats", nb, 0);

    @(posedge clk); #1;
    fork
      send(2, 8'h5A, 1'b0);
      collect(2, 6, st, nb, ns, nl, idle, rlow);
    join
    lit("one_beat_word", st, 32'h5A);
    lit("one_beat_framing", nb * 256 + ns * 16 + nl, 16'h111);
    @(posedge clk); #1;
    fork
      begin
        send(2, 8'h11, 1'b1);
        send(2, 8'h22, 1'b0);
        send(2, 8'h33, 1'b1);
        send(2, 8'h44, 1'b0);
      end
      collect(2, 12, st, nb, ns, nl, idle, rlow);
    join
    lit("stream_words", st, 32'h11223344);
    lit("stream_idle", idle, 0);
    lit("stream_ready_low", rlow, 0);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
